// File: rtl/mine_pkg.sv
// Shared definitions for the minesweeper game controller: default geometry,
// square-state encoding, direction codes, FSM states and an adjacency helper.
// Optional build macro: MINE_FLAG_EN (flag support, used by the other files).
package mine_pkg;

    localparam int GRID_SIZE  = 3;
    localparam int STATE_SIZE = 4;

    localparam logic [3:0] STATE_BOMB = 4'd9;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_MOVE  = 3'd2,
        ST_FLOOD = 3'd3,
        ST_LOST  = 3'd4,
        ST_WON   = 3'd5
    } game_state_t;

    // Squares a and b touch (8-neighbourhood) on a g x g board; index = row*g + col
    function automatic logic is_adjacent(input int a, input int b, input int g);
        int dr;
        int dc;
        dr = (a / g) - (b / g);
        dc = (a % g) - (b % g);
        if (dr < 0) dr = -dr;
        if (dc < 0) dc = -dc;
        return (a != b) && (dr <= 1) && (dc <= 1);
    endfunction

endpackage

// File: rtl/mine_game_ctrl_if.sv
// Bundle of button, board and status signals around the game controller.
// master = controller side, slave = buttons/board side.
// Optional build macro: MINE_FLAG_EN adds btn_flag and flag_grid.
interface mine_game_ctrl_if #(
    parameter int N          = mine_pkg::GRID_SIZE * mine_pkg::GRID_SIZE,
    parameter int STATE_SIZE = mine_pkg::STATE_SIZE
);
    logic                    load;
    logic [N-1:0]            load_bombs;
    logic                    btn_move;
    logic [1:0]              btn_dir;
    logic                    btn_reveal;
    logic [STATE_SIZE*N-1:0] states;
    logic [N-1:0]            next_cursor;
    logic [N-1:0]            bomb_grid;
    logic [N-1:0]            reveal_grid;
    logic [N-1:0]            cursor_grid;
    logic                    move;
    logic [1:0]              dir;
    logic                    busy;
    logic                    game_over;
    logic                    game_won;
`ifdef MINE_FLAG_EN
    logic                    btn_flag;
    logic [N-1:0]            flag_grid;
`endif

    modport master (
`ifdef MINE_FLAG_EN
        input  btn_flag,
        output flag_grid,
`endif
        input  load, load_bombs, btn_move, btn_dir, btn_reveal, states, next_cursor,
        output bomb_grid, reveal_grid, cursor_grid, move, dir, busy, game_over, game_won
    );

    modport slave (
`ifdef MINE_FLAG_EN
        output btn_flag,
        input  flag_grid,
`endif
        output load, load_bombs, btn_move, btn_dir, btn_reveal, states, next_cursor,
        input  bomb_grid, reveal_grid, cursor_grid, move, dir, busy, game_over, game_won
    );

endinterface

// File: rtl/mine_flood_step.sv
// One step of the zero-region flood: every unrevealed, non-bomb square touching
// a revealed zero square becomes revealed. changed reports whether anything grew.
// Optional build macro: MINE_FLAG_EN (flagged squares are never flooded).
module mine_flood_step #(
    parameter int  GRID_SIZE = mine_pkg::GRID_SIZE,
    localparam int N         = GRID_SIZE * GRID_SIZE
) (
    input  logic [N-1:0] reveal,
    input  logic [N-1:0] bomb,
    input  logic [N-1:0] zero,
`ifdef MINE_FLAG_EN
    input  logic [N-1:0] flag,
`endif
    output logic [N-1:0] next_reveal,
    output logic         changed
);
    import mine_pkg::*;

    logic [N-1:0] seed;
    logic [N-1:0] grow;
    logic [N-1:0] eligible;

    // Grow the revealed set by one ring around every revealed zero square
    always_comb begin
        seed = reveal & zero;
        grow = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (seed[i] && is_adjacent(i, j, GRID_SIZE)) grow[j] = 1'b1;
            end
        end
`ifdef MINE_FLAG_EN
        eligible = ~bomb & ~flag;
`else
        eligible = ~bomb;
`endif
        next_reveal = reveal | (grow & eligible);
        changed     = (next_reveal != reveal);
    end

endmodule

// File: rtl/mine_game_ctrl.sv
// Game controller for the combinational minesweeper board: holds bomb, reveal
// and cursor grids, turns button pulses into board move strobes, runs the
// iterative flood reveal and tracks loss/win.
// Optional build macro: MINE_FLAG_EN adds per-square flags (btn_flag/flag_grid).
module mine_game_ctrl #(
    parameter int GRID_SIZE  = mine_pkg::GRID_SIZE,
    parameter int STATE_SIZE = mine_pkg::STATE_SIZE
) (
    input logic              clk,
    input logic              rst_n,
    mine_game_ctrl_if.master bus
);
    import mine_pkg::*;

    localparam int           N           = GRID_SIZE * GRID_SIZE;
    localparam int           CNT_W       = $clog2(N + 1);
    localparam logic [N-1:0] CURSOR_HOME = {1'b1, {(N-1){1'b0}}};

    game_state_t          state_q, state_d;
    logic [N-1:0]         bomb_q, bomb_d;
    logic [N-1:0]         reveal_q, reveal_d;
    logic [N-1:0]         cursor_q, cursor_d;
    logic                 move_q, move_d;
    logic [1:0]           dir_q, dir_d;
    logic                 over_q, over_d;
    logic                 won_q, won_d;
    logic [CNT_W-1:0]     flood_cnt_q, flood_cnt_d;
`ifdef MINE_FLAG_EN
    logic [N-1:0]         flag_q, flag_d;
`endif

    logic [STATE_SIZE-1:0] cur_state;
    logic [N-1:0]          zero_mask;
    logic                  cursor_blocked;
    logic [N-1:0]          flood_next;
    logic                  flood_changed;

    // Board is solved once every square is either revealed or a bomb
    function automatic logic all_cleared(input logic [N-1:0] rv, input logic [N-1:0] bm);
        return &(rv | bm);
    endfunction

    // Decode board states: zero-count mask and the state under the cursor
    always_comb begin
        cur_state = '0;
        zero_mask = '0;
        for (int k = 0; k < N; k++) begin
            zero_mask[k] = (bus.states[k*STATE_SIZE +: STATE_SIZE] == '0);
            if (cursor_q[k]) cur_state = cur_state | bus.states[k*STATE_SIZE +: STATE_SIZE];
        end
    end

`ifdef MINE_FLAG_EN
    assign cursor_blocked = |(cursor_q & (reveal_q | flag_q));
`else
    assign cursor_blocked = |(cursor_q & reveal_q);
`endif

    mine_flood_step #(
        .GRID_SIZE (GRID_SIZE)
    ) u_flood (
        .reveal      (reveal_q),
        .bomb        (bomb_q),
        .zero        (zero_mask),
`ifdef MINE_FLAG_EN
        .flag        (flag_q),
`endif
        .next_reveal (flood_next),
        .changed     (flood_changed)
    );

    // State and game registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bomb_q      <= '0;
            reveal_q    <= '0;
            cursor_q    <= '0;
            move_q      <= 1'b0;
            dir_q       <= 2'b00;
            over_q      <= 1'b0;
            won_q       <= 1'b0;
            flood_cnt_q <= '0;
`ifdef MINE_FLAG_EN
            flag_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bomb_q      <= bomb_d;
            reveal_q    <= reveal_d;
            cursor_q    <= cursor_d;
            move_q      <= move_d;
            dir_q       <= dir_d;
            over_q      <= over_d;
            won_q       <= won_d;
            flood_cnt_q <= flood_cnt_d;
`ifdef MINE_FLAG_EN
            flag_q      <= flag_d;
`endif
        end
    end

    // Next-state logic: load overrides everything, then per-state button handling
    always_comb begin
        state_d     = state_q;
        bomb_d      = bomb_q;
        reveal_d    = reveal_q;
        cursor_d    = cursor_q;
        move_d      = 1'b0;
        dir_d       = dir_q;
        over_d      = over_q;
        won_d       = won_q;
        flood_cnt_d = flood_cnt_q;
`ifdef MINE_FLAG_EN
        flag_d      = flag_q;
`endif

        if (bus.load) begin
            bomb_d      = bus.load_bombs;
            reveal_d    = '0;
            cursor_d    = CURSOR_HOME;
            over_d      = 1'b0;
            won_d       = 1'b0;
            flood_cnt_d = '0;
`ifdef MINE_FLAG_EN
            flag_d      = '0;
`endif
            state_d     = ST_PLAY;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (bus.btn_reveal) begin
                        if (!cursor_blocked) begin
                            if (cur_state == STATE_SIZE'(STATE_BOMB)) begin
                                reveal_d = reveal_q | bomb_q;
                                over_d   = 1'b1;
                                state_d  = ST_LOST;
                            end else if (cur_state == '0) begin
                                reveal_d    = reveal_q | cursor_q;
                                flood_cnt_d = '0;
                                state_d     = ST_FLOOD;
                            end else begin
                                reveal_d = reveal_q | cursor_q;
                                if (all_cleared(reveal_q | cursor_q, bomb_q)) begin
                                    won_d   = 1'b1;
                                    state_d = ST_WON;
                                end
                            end
                        end
                    end
`ifdef MINE_FLAG_EN
                    else if (bus.btn_flag) begin
                        if (!(|(cursor_q & reveal_q))) flag_d = flag_q ^ cursor_q;
                    end
`endif
                    else if (bus.btn_move) begin
                        dir_d   = bus.btn_dir;
                        move_d  = 1'b1;
                        state_d = ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    cursor_d = bus.next_cursor;
                    state_d  = ST_PLAY;
                end
                ST_FLOOD: begin
                    reveal_d    = flood_next;
                    flood_cnt_d = flood_cnt_q + CNT_W'(1);
                    if (!flood_changed || (flood_cnt_q == CNT_W'(N - 1))) begin
                        if (all_cleared(flood_next, bomb_q)) begin
                            won_d   = 1'b1;
                            state_d = ST_WON;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bomb_grid   = bomb_q;
    assign bus.reveal_grid = reveal_q;
    assign bus.cursor_grid = cursor_q;
    assign bus.move        = move_q;
    assign bus.dir         = dir_q;
    assign bus.busy        = (state_q == ST_MOVE) || (state_q == ST_FLOOD);
    assign bus.game_over   = over_q;
    assign bus.game_won    = won_q;
`ifdef MINE_FLAG_EN
    assign bus.flag_grid   = flag_q;
`endif

endmodule
